// File: rtl/addsub_seq_8bit.sv
// addsub_seq_8bit: sequencing and flag stage ahead of a combinational adder.
// Registers a command, drives the adder, captures sum/carry and Z/N/C/V flags.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     command handshake
//   in_a, in_b            operands
//   in_op                 0 = add, 1 = subtract
//   in_chain              1 = use stored carry as carry-in
//   dp_a, dp_b, dp_cin    to external adder (dp_b pre-inverted for subtract)
//   dp_sum, dp_cout       from external adder
//   out_valid/out_ready   result handshake
//   out_res               result
//   out_c/z/n/v           carry (1 = no borrow), zero, negative, overflow
module addsub_seq_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_chain,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_cin,
  input  logic [WIDTH-1:0] dp_sum,
  input  logic             dp_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb_eff;
  logic             rcin;
  logic             chain_c;
  logic             acc;

  assign in_ready = (state == IDLE)
                  | ((state == HOLD) & out_ready);
  assign acc      = in_valid & in_ready;

  assign dp_a   = ra;
  assign dp_b   = rb_eff;
  assign dp_cin = rcin;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (acc) state_n = EXEC;
      EXEC: state_n = HOLD;
      HOLD: begin
        if (out_ready)
          state_n = in_valid ? EXEC : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ra        <= '0;
      rb_eff    <= '0;
      rcin      <= 1'b0;
      chain_c   <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_c     <= 1'b0;
      out_z     <= 1'b0;
      out_n     <= 1'b0;
      out_v     <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        ra     <= in_a;
        rb_eff <= in_op ? ~in_b : in_b;
        // plain subtract needs cin=1 to finish the two's complement
        rcin   <= in_chain ? chain_c : in_op;
      end
      if (state == EXEC) begin
        out_res   <= dp_sum;
        out_c     <= dp_cout;
        out_z     <= (dp_sum == '0);
        out_n     <= dp_sum[WIDTH-1];
        // operands share a sign but the sum does not
        out_v     <= (ra[WIDTH-1] == rb_eff[WIDTH-1])
                   & (dp_sum[WIDTH-1] != ra[WIDTH-1]);
        chain_c   <= dp_cout;
        out_valid <= 1'b1;
      end else if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
